// File: rtl/seq_divider_32bit.sv
// rtl/seq_divider_32bit.sv - 32-bit restoring shift-and-subtract divider, one quotient bit per clock
// Optional signed mode: define DIV_SIGNED_EN to add the signed_op port.
module seq_divider_32bit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
`ifdef DIV_SIGNED_EN
    input  logic        signed_op,
`endif
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] q_q, q_d;
    logic [31:0] d_q, d_d;
    logic [31:0] r_q, r_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        dz_q, dz_d;
    logic        quo_neg_q, quo_neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic [31:0] quotient_q, quotient_d;
    logic [31:0] remainder_q, remainder_d;
    logic        dbz_q, dbz_d;

    logic        accept;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] r_sh, trial;
    logic [31:0] r_new, q_sh;

`ifdef DIV_SIGNED_EN
    assign a_neg = signed_op & dividend[31];
    assign b_neg = signed_op & divisor[31];
`else
    assign a_neg = 1'b0;
    assign b_neg = 1'b0;
`endif
    assign a_mag  = a_neg ? -dividend : dividend;
    assign b_mag  = b_neg ? -divisor  : divisor;
    assign accept = start && (state_q != RUN);

    // The partial remainder is always below D, so only the shifted value needs the 33rd bit.
    assign r_sh  = {r_q, q_q[31]};
    assign trial = r_sh - {1'b0, d_q};
    assign r_new = trial[32] ? r_sh[31:0] : trial[31:0];
    assign q_sh  = {q_q[30:0], ~trial[32]};

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        d_d         = d_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        dz_d        = dz_q;
        quo_neg_d   = quo_neg_q;
        rem_neg_d   = rem_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            RUN: begin
                if (dz_q) begin
                    // q_q holds the raw dividend on a divide-by-zero accept.
                    quotient_d  = 32'hFFFF_FFFF;
                    remainder_d = q_q;
                    dbz_d       = 1'b1;
                    state_d     = DONE;
                end else begin
                    q_d   = q_sh;
                    r_d   = r_new;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        quotient_d  = quo_neg_q ? -q_sh  : q_sh;
                        remainder_d = rem_neg_q ? -r_new : r_new;
                        dbz_d       = 1'b0;
                        state_d     = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            q_d       = (divisor == 32'd0) ? dividend : a_mag;
            d_d       = b_mag;
            r_d       = 32'd0;
            cnt_d     = 6'd0;
            dz_d      = (divisor == 32'd0);
            quo_neg_d = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            state_d   = RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            q_q         <= 32'd0;
            d_q         <= 32'd0;
            r_q         <= 32'd0;
            cnt_q       <= 6'd0;
            dz_q        <= 1'b0;
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            quotient_q  <= 32'd0;
            remainder_q <= 32'd0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            d_q         <= d_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            dz_q        <= dz_d;
            quo_neg_q   <= quo_neg_d;
            rem_neg_q   <= rem_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_32bit.sv
// tb/tb_seq_divider_32bit.sv - directed self-checking bench for seq_divider_32bit
module tb_seq_divider_32bit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        signed_op;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_divider_32bit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef DIV_SIGNED_EN
        .signed_op   (signed_op),
`endif
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er,
                           input logic edz, input int elat, input logic sop);
        int lat;
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b; signed_op = sop;
        @(posedge clk);
        #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_done(lat);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_dz"}, {31'd0, div_by_zero}, {31'd0, edz});
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int lat;
        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0; signed_op = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);
        check("rst_dz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_div("u100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 1'b0);
        run_div("max_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32, 1'b0);
        run_div("5_max", 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd5, 1'b0, 32, 1'b0);
        run_div("dz1234", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1, 1'b0);
        run_div("u1000_10", 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 32, 1'b0);

        // reset mid-run with start held
        @(negedge clk);
        start = 1'b1; dividend = 32'd100000; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1; start = 1'b1;
        #1;
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_done", {31'd0, done}, 32'd0);
        check("mrst_q", quotient, 32'd0);
        check("mrst_r", remainder, 32'd0);
        check("mrst_dz", {31'd0, div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0; start = 1'b0;
        run_div("post_rst", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 1'b0);

        // start re-pulsed during RUN is ignored
        @(negedge clk);
        start = 1'b1; dividend = 32'd1000; divisor = 32'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 5) begin
                check("run_old_q", quotient, 32'd14);
                start = 1'b1; dividend = 32'd7; divisor = 32'd7;
            end else begin
                start = 1'b0;
            end
        end
        check("repulse_lat", lat, 32);
        check("repulse_q", quotient, 32'd100);
        check("repulse_r", remainder, 32'd0);

        // start held high: back-to-back results every 33 cycles
        @(negedge clk);
        start = 1'b1; dividend = 32'd50; divisor = 32'd3;
        @(posedge clk);
        #1;
        wait_done(lat);
        check("b2b_lat1", lat, 32);
        check("b2b_q1", quotient, 32'd16);
        check("b2b_r1", remainder, 32'd2);
        dividend = 32'd77; divisor = 32'd10;
        @(posedge clk);
        #1;
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check("b2b_gap", lat, 33);
        check("b2b_q2", quotient, 32'd7);
        check("b2b_r2", remainder, 32'd7);
        repeat (2) @(posedge clk);
        #1;
        check("b2b_idle", {30'd0, busy, done}, 32'd0);

`ifdef DIV_SIGNED_EN
        run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32, 1'b1);
        run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 32, 1'b1);
        run_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 32, 1'b1);
        run_div("s_dz", 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
